// File: rtl/core_pkg.sv
// Shared definitions for the memory stage: access-size codes, the memory-stage
// state type, and small helpers for alignment, byte enables and lane
// replication of store data.
package core_pkg;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    // Size code 3 is reserved and behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = off[0];
            default:  mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << off;
            MEM_HALF: be = 4'b0011 << off;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the operand across lanes lets the byte enables alone pick
    // the destination bytes, so no shifter is needed on the write path.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] wd;
        case (size)
            MEM_BYTE: wd = {4{sd[7:0]}};
            MEM_HALF: wd = {2{sd[15:0]}};
            default:  wd = sd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port.
//   master : memory stage side (drives request, write flag, address, data, enables)
//   slave  : memory side (returns acknowledge and read data)
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte or halfword out of
// the returned word and sign- or zero-extends it to 32 bits.
//   i_rdata    : word returned by data memory
//   i_off      : byte offset of the access within the word
//   i_size     : access size code (byte/half/word, 3 = word)
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : aligned, extended writeback value
module load_align
    import core_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Halfwords are only ever accepted at offsets 0 or 2.
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_size)
            MEM_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            MEM_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage of the 5-stage core. Turns load/store ops from execute into a
// req/ack transaction on the data-memory port, stalls upstream while the
// transaction is outstanding, and registers writeback data. Non-memory ops
// pass aluout through with one cycle of latency.
//
//   state | meaning
//   IDLE  | ready for a new op from execute
//   BUSY  | request outstanding, waiting for dmem_ack or timeout
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   ex_valid, aluout, addr,
//   store_data, mem_rd,
//   mem_wr, mem_size,
//   mem_unsigned, rd         : execute-stage op
//   stall                    : hold execute and earlier stages
//   dmem                     : data-memory port (master side)
//   wb_valid, wb_data, wb_rd : writeback, one-cycle pulse per completed op
//   misalign                 : pulse, misaligned access dropped
//   bus_err                  : pulse, request timed out and was abandoned
module mem_access
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic [31:0]         aluout,
    input  logic [31:0]         addr,
    input  logic [31:0]         store_data,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic [4:0]          rd,
    output logic                stall,
    mem_access_if.master        dmem,
    output logic                wb_valid,
    output logic [31:0]         wb_data,
    output logic [4:0]          wb_rd,
    output logic                misalign,
    output logic                bus_err
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;

    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [4:0]        r_rd;
    logic [TCNT_W-1:0] r_tcnt;

    logic              r_wb_valid;
    logic [31:0]       r_wb_data;
    logic [4:0]        r_wb_rd;
    logic              r_misalign;
    logic              r_bus_err;

    logic              w_mem_op;
    logic              w_misaligned;
    logic              w_pass;
    logic              w_reject;
    logic              w_accept;
    logic              w_ack;
    logic              w_expire;
    logic [31:0]       w_load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mem_op     = mem_rd | mem_wr;
        w_misaligned = is_misaligned(mem_size, addr[1:0]);
        w_pass       = 1'b0;
        w_reject     = 1'b0;
        w_accept     = 1'b0;
        w_ack        = 1'b0;
        w_expire     = 1'b0;
        stall        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!w_mem_op) begin
                        w_pass = 1'b1;
                    end else if (w_misaligned) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        stall       = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                w_ack    = r_req & dmem.dmem_ack;
                // Ack takes priority over an expiry landing in the same cycle.
                w_expire = ~w_ack & (r_tcnt == TCNT_LAST);
                stall    = ~w_ack;
                if (w_ack || w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    load_align u_load_align (
        .i_rdata    (dmem.dmem_rdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_rd       <= '0;
            r_tcnt     <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;

            if (w_pass) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= aluout;
                r_wb_rd    <= rd;
            end

            if (w_reject) begin
                r_misalign <= 1'b1;
            end

            if (w_accept) begin
                r_req      <= 1'b1;
                r_we       <= mem_wr;
                r_addr     <= {addr[31:2], 2'b00};
                r_wdata    <= lane_wdata(mem_size, store_data);
                r_be       <= byte_en(mem_size, addr[1:0]);
                r_off      <= addr[1:0];
                r_size     <= mem_size;
                r_unsigned <= mem_unsigned;
                r_rd       <= rd;
                r_tcnt     <= '0;
            end

            if (w_ack) begin
                r_req <= 1'b0;
                r_we  <= 1'b0;
                if (!r_we) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= w_load_data;
                    r_wb_rd    <= r_rd;
                end
            end else if (w_expire) begin
                r_req     <= 1'b0;
                r_we      <= 1'b0;
                r_bus_err <= 1'b1;
            end else if (r_state == ST_BUSY) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_be    = r_be;

    assign wb_valid = r_wb_valid;
    assign wb_data  = r_wb_data;
    assign wb_rd    = r_wb_rd;
    assign misalign = r_misalign;
    assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] aluout = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        mem_unsigned = 1'b0;
    logic [4:0]  rd = '0;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misalign;
    logic        bus_err;

    int checks = 0;
    int failures = 0;

    mem_access_if u_if ();

    mem_access #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .aluout       (aluout),
        .addr         (addr),
        .store_data   (store_data),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .rd           (rd),
        .stall        (stall),
        .dmem         (u_if),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, with size 3 acting as a word.
    function automatic int width_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) % width_of(sz)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
        logic [3:0] be;
        int w;
        int off;
        be  = '0;
        w   = width_of(sz);
        off = int'(a[1:0]);
        for (int i = 0; i < w; i++) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input logic [1:0] sz);
        logic [31:0] r;
        int w;
        r = '0;
        w = width_of(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % w) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        int w;
        w = width_of(sz);
        v = rdata >> (8 * int'(a[1:0]));
        if (w == 1) begin
            v = {24'h0, v[7:0]};
            if (!uns && v[7]) v[31:8] = '1;
        end else if (w == 2) begin
            v = {16'h0, v[15:0]};
            if (!uns && v[15]) v[31:16] = '1;
        end
        return v;
    endfunction

    task automatic drive_idle();
        ex_valid = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. delay = BUSY cycles before ack;
    // delay >= TIMEOUT means the memory never answers.
    task automatic run_op(input string nm, input int kind, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] alu,
                          input logic [1:0] sz, input bit uns, input logic [4:0] r,
                          input int delay, input logic [31:0] rdata);
        bit mis;
        bit acked;
        int stall_cnt;
        mis = (kind != 0) && ref_misaligned(a, sz);
        @(posedge clk); #1;
        ex_valid     = 1'b1;
        aluout       = alu;
        addr         = a;
        store_data   = sd;
        mem_rd       = (kind == 1);
        mem_wr       = (kind == 2);
        mem_size     = sz;
        mem_unsigned = uns;
        rd           = r;
        @(negedge clk);
        chk1({nm, "_accept_stall"}, stall, (kind != 0) && !mis);
        if (kind == 0 || mis) begin
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            chk1({nm, "_wb_valid"}, wb_valid, kind == 0);
            chk1({nm, "_misalign"}, misalign, mis);
            chk1({nm, "_no_req"}, u_if.dmem_req, 1'b0);
            chk1({nm, "_no_stall"}, stall, 1'b0);
            if (kind == 0) begin
                chk32({nm, "_wb_data"}, wb_data, alu);
                chk32({nm, "_wb_rd"}, 32'(wb_rd), 32'(r));
            end
            @(negedge clk);
            chk1({nm, "_misalign_pulse"}, misalign, 1'b0);
            chk1({nm, "_wb_pulse"}, wb_valid, 1'b0);
            return;
        end
        stall_cnt = 1;
        acked     = 1'b0;
        for (int k = 0; k < TIMEOUT && !acked; k++) begin
            @(negedge clk);
            chk1({nm, "_req"}, u_if.dmem_req, 1'b1);
            chk1({nm, "_we"}, u_if.dmem_we, kind == 2);
            chk32({nm, "_addr"}, u_if.dmem_addr, {a[31:2], 2'b00});
            chk32({nm, "_be"}, 32'(u_if.dmem_be), 32'(ref_be(a, sz)));
            if (kind == 2) chk32({nm, "_wdata"}, u_if.dmem_wdata, ref_wdata(sd, sz));
            if (k == delay) begin
                u_if.dmem_ack   = 1'b1;
                u_if.dmem_rdata = rdata;
                #1;
                chk1({nm, "_ack_stall"}, stall, 1'b0);
                acked = 1'b1;
            end else begin
                chk1({nm, "_busy_stall"}, stall, 1'b1);
                if (stall === 1'b1) stall_cnt++;
            end
            @(posedge clk); #1;
            u_if.dmem_ack   = 1'b0;
            u_if.dmem_rdata = 32'h0BAD_F00D;
        end
        drive_idle();
        chk32({nm, "_stall_cycles"}, 32'(stall_cnt),
              32'((delay < TIMEOUT) ? delay + 1 : TIMEOUT + 1));
        @(negedge clk);
        chk1({nm, "_req_low"}, u_if.dmem_req, 1'b0);
        chk1({nm, "_idle_stall"}, stall, 1'b0);
        chk1({nm, "_bus_err"}, bus_err, !acked);
        chk1({nm, "_wb_valid"}, wb_valid, acked && kind == 1);
        if (acked && kind == 1) begin
            chk32({nm, "_wb_data"}, wb_data, ref_load(rdata, a, sz, uns));
            chk32({nm, "_wb_rd"}, 32'(wb_rd), 32'(r));
        end
        @(negedge clk);
        chk1({nm, "_bus_err_pulse"}, bus_err, 1'b0);
        chk1({nm, "_wb_pulse"}, wb_valid, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk1({nm, "_req"}, u_if.dmem_req, 1'b0);
        chk1({nm, "_we"}, u_if.dmem_we, 1'b0);
        chk32({nm, "_addr"}, u_if.dmem_addr, 32'h0);
        chk32({nm, "_wdata"}, u_if.dmem_wdata, 32'h0);
        chk32({nm, "_be"}, 32'(u_if.dmem_be), 32'h0);
        chk1({nm, "_wb_valid"}, wb_valid, 1'b0);
        chk32({nm, "_wb_data"}, wb_data, 32'h0);
        chk32({nm, "_wb_rd"}, 32'(wb_rd), 32'h0);
        chk1({nm, "_misalign"}, misalign, 1'b0);
        chk1({nm, "_bus_err"}, bus_err, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        logic [1:0] sz;
        logic [31:0] a;

        u_if.dmem_ack   = 1'b0;
        u_if.dmem_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        chk1("reset_stall", stall, 1'b0);
        rst_n = 1'b1;

        run_op("ld_word_0x100", 1, 32'h100, 32'h0, 32'h0, 2'd2, 1'b0, 5'd3, 3, 32'hDEAD_BEEF);
        chk32("ld_word_0x100_value", wb_data, 32'hDEAD_BEEF);
        run_op("ld_byte_s", 1, 32'h103, 32'h0, 32'h0, 2'd0, 1'b0, 5'd4, 1, 32'h80FF_1234);
        chk32("ld_byte_s_value", wb_data, 32'hFFFF_FF80);
        run_op("ld_byte_u", 1, 32'h103, 32'h0, 32'h0, 2'd0, 1'b1, 5'd5, 0, 32'h80FF_1234);
        chk32("ld_byte_u_value", wb_data, 32'h0000_0080);
        run_op("st_half_0x202", 2, 32'h202, 32'h0000_ABCD, 32'h0, 2'd1, 1'b0, 5'd6, 2, 32'h0);
        run_op("ld_half_s", 1, 32'h2002, 32'h0, 32'h0, 2'd1, 1'b0, 5'd9, 2, 32'h8001_7FFF);
        run_op("ld_word_mis", 1, 32'h101, 32'h0, 32'h0, 2'd2, 1'b0, 5'd7, 0, 32'h0);
        run_op("ld_half_mis", 1, 32'h301, 32'h0, 32'h0, 2'd1, 1'b0, 5'd7, 0, 32'h0);
        run_op("st_rsvd_size", 2, 32'h40, 32'h1234_5678, 32'h0, 2'd3, 1'b0, 5'd8, 1, 32'h0);
        run_op("alu", 0, 32'h0, 32'h0, 32'hCAFE_0001, 2'd0, 1'b0, 5'd10, 0, 32'h0);
        run_op("ld_timeout", 1, 32'h500, 32'h0, 32'h0, 2'd2, 1'b0, 5'd11, TIMEOUT + 10, 32'h0);
        run_op("alu_after_to", 0, 32'h0, 32'h0, 32'h1357_9BDF, 2'd0, 1'b0, 5'd12, 0, 32'h0);
        run_op("ld_ack_at_expiry", 1, 32'h600, 32'h0, 32'h0, 2'd2, 1'b0, 5'd13, TIMEOUT - 1,
               32'h5555_AAAA);

        // Acknowledge while idle must be ignored.
        @(posedge clk); #1;
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            chk1("idle_ack_req", u_if.dmem_req, 1'b0);
            chk1("idle_ack_wb", wb_valid, 1'b0);
            chk1("idle_ack_stall", stall, 1'b0);
        end
        @(posedge clk); #1;
        u_if.dmem_ack = 1'b0;
        run_op("ld_after_idle_ack", 1, 32'h700, 32'h0, 32'h0, 2'd2, 1'b0, 5'd14, 0, 32'h0102_0304);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            run_op("rand", kind, a, $urandom, $urandom, sz, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), int'($urandom_range(0, 4)), $urandom);
        end

        // Reset two cycles into BUSY drops the request without waiting for a clock.
        @(posedge clk); #1;
        ex_valid = 1'b1;
        mem_rd   = 1'b1;
        mem_wr   = 1'b0;
        addr     = 32'h300;
        mem_size = 2'd2;
        rd       = 5'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_busy_req", u_if.dmem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        chk1("rst_async_req", u_if.dmem_req, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all_zero("post_rst");
        chk1("post_rst_stall", stall, 1'b0);
        run_op("alu_post_rst", 0, 32'h0, 32'h0, 32'h0BAD_CAFE, 2'd0, 1'b0, 5'd15, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
